// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg: shared Y86-64 execute-stage codes and constants
package execute_stage_pkg;
  localparam int W = 64;
  localparam logic [3:0] IHALT = 4'h0, INOP = 4'h1, IRRMOVQ = 4'h2, IIRMOVQ = 4'h3,
                         IRMMOVQ = 4'h4, IMRMOVQ = 4'h5, IOPQ = 4'h6, IJXX = 4'h7,
                         ICALL = 4'h8, IRET = 4'h9, IPUSHQ = 4'hA, IPOPQ = 4'hB;
  localparam logic [3:0] ALUADD = 4'h0, ALUSUB = 4'h1, ALUAND = 4'h2, ALUXOR = 4'h3;
  localparam logic [3:0] C_YES = 4'h0, C_LE = 4'h1, C_L = 4'h2, C_E = 4'h3,
                         C_NE = 4'h4, C_GE = 4'h5, C_G = 4'h6;
  localparam logic [1:0] SAOK = 2'd0, SHLT = 2'd1, SADR = 2'd2, SINS = 2'd3;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [2:0] CC_RESET = 3'b100;
endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if: E-register inputs, pipeline control and M-register outputs
interface execute_stage_if;
  import execute_stage_pkg::*;
  logic [3:0] E_icode, E_ifun, E_dstE, E_dstM;
  logic [W-1:0] E_valA, E_valB, E_valC;
  logic [1:0] E_stat, m_stat, W_stat;
  logic M_bubble, M_stall;
  logic [W-1:0] e_valE;
  logic [3:0] e_dstE;
  logic e_Cnd;
  logic [3:0] M_icode, M_dstE, M_dstM;
  logic M_Cnd;
  logic [W-1:0] M_valE, M_valA;
  logic [1:0] M_stat;
  logic [2:0] cc_out;
  modport master (
    output E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM, E_stat,
           m_stat, W_stat, M_bubble, M_stall,
    input  e_valE, e_dstE, e_Cnd, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
           M_stat, cc_out
  );
  modport slave (
    input  E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM, E_stat,
           m_stat, W_stat, M_bubble, M_stall,
    output e_valE, e_dstE, e_Cnd, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM,
           M_stat, cc_out
  );
endinterface

// File: rtl/execute_stage_alu_cc.sv
// alu_cc: combinational Y86-64 ALU with ZF/SF/OF generation
module alu_cc
  import execute_stage_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   fun,
  output logic [W-1:0] result,
  output logic         zf,
  output logic         sf,
  output logic         of
);
  always_comb begin
    result = fun == ALUADD ? b + a :
             fun == ALUSUB ? b - a :
             fun == ALUAND ? b & a :
             fun == ALUXOR ? b ^ a : '0;
    zf = result == '0;
    sf = result[W-1];
    of = fun == ALUADD ? (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]) :
         fun == ALUSUB ? (a[W-1] != b[W-1]) && (result[W-1] != b[W-1]) : 1'b0;
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 execute stage - ALU, condition codes, branch/cmov test, M register
module execute_stage
  import execute_stage_pkg::*;
(
  input logic clk,
  input logic rst,
  execute_stage_if.slave bus
);
  logic [W-1:0] alu_a, alu_b, result;
  logic [3:0] alu_fun;
  logic zf, sf, of, cond, set_cc;
  logic [2:0] cc;
  always_comb begin
    alu_a = (bus.E_icode == IRRMOVQ || bus.E_icode == IOPQ) ? bus.E_valA :
            (bus.E_icode == IIRMOVQ || bus.E_icode == IRMMOVQ || bus.E_icode == IMRMOVQ) ? bus.E_valC :
            (bus.E_icode == ICALL || bus.E_icode == IPUSHQ) ? -W'(8) :
            (bus.E_icode == IRET || bus.E_icode == IPOPQ) ? W'(8) : '0;
    alu_b = (bus.E_icode inside {IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ}) ? bus.E_valB : '0;
    alu_fun = bus.E_icode == IOPQ ? bus.E_ifun : ALUADD;
  end
  alu_cc u_alu (.a(alu_a), .b(alu_b), .fun(alu_fun), .result(result), .zf(zf), .sf(sf), .of(of));
  // conditions read the registered CC; an OPq in this cycle only affects the next instruction
  always_comb begin
    cond = bus.E_ifun == C_YES ? 1'b1 :
           bus.E_ifun == C_LE  ? (cc[1] ^ cc[0]) | cc[2] :
           bus.E_ifun == C_L   ? cc[1] ^ cc[0] :
           bus.E_ifun == C_E   ? cc[2] :
           bus.E_ifun == C_NE  ? ~cc[2] :
           bus.E_ifun == C_GE  ? ~(cc[1] ^ cc[0]) :
           bus.E_ifun == C_G   ? ~(cc[1] ^ cc[0]) & ~cc[2] : 1'b0;
    bus.e_Cnd = (bus.E_icode == IRRMOVQ || bus.E_icode == IJXX) ? cond : 1'b0;
    bus.e_dstE = (bus.E_icode == IRRMOVQ && !bus.e_Cnd) ? RNONE : bus.E_dstE;
    bus.e_valE = result;
    set_cc = bus.E_icode == IOPQ && bus.m_stat == SAOK && bus.W_stat == SAOK && bus.E_stat == SAOK;
    bus.cc_out = cc;
  end
  always_ff @(posedge clk) begin
    if (rst) cc <= CC_RESET;
    else if (set_cc) cc <= {zf, sf, of};
  end
  always_ff @(posedge clk) begin
    if (rst || (bus.M_bubble && !bus.M_stall)) begin
      bus.M_icode <= INOP;
      bus.M_Cnd <= 1'b0;
      bus.M_valE <= '0;
      bus.M_valA <= '0;
      bus.M_dstE <= RNONE;
      bus.M_dstM <= RNONE;
      bus.M_stat <= SAOK;
    end else if (!bus.M_stall) begin
      bus.M_icode <= bus.E_icode;
      bus.M_Cnd <= bus.e_Cnd;
      bus.M_valE <= bus.e_valE;
      bus.M_valA <= bus.E_valA;
      bus.M_dstE <= bus.e_dstE;
      bus.M_dstM <= bus.E_dstM;
      bus.M_stat <= bus.E_stat;
    end
  end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Y86-64 pipeline execute stage. Sits between the decode/E pipeline register and the memory stage.
- Computes the ALU result, evaluates branch and cmov conditions against the condition-code register (CC), and updates CC.
- Registers results into the M pipeline register that the memory stage consumes.
- Exports e_valE, e_dstE and e_Cnd combinationally for forwarding and for branch-mispredict detection.

Parameters:
- W, 64, datapath width.
- RNONE, 4'hF, "no register" destination code.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- E_icode  in  4  instruction code.
- E_ifun  in  4  function code.
- E_valA, E_valB, E_valC  in  W each  operand values.
- E_dstE, E_dstM  in  4  destination registers.
- E_stat  in  2  status; 0=AOK, 1=HLT, 2=ADR, 3=INS.
- m_stat  in  2  status currently in the memory stage.
- W_stat  in  2  status currently in the write-back stage.
- M_bubble  in  1  load a nop into the M register this edge.
- M_stall  in  1  hold the M register.
- e_valE  out  W  combinational ALU result.
- e_dstE  out  4  combinational destination; RNONE for a not-taken cmov.
- e_Cnd  out  1  combinational condition result.
- M_icode  out  4  registered to memory stage.
- M_Cnd  out  1  registered to memory stage.
- M_valE  out  W  registered to memory stage.
- M_valA  out  W  registered to memory stage.
- M_dstE, M_dstM  out  4  registered to memory stage.
- M_stat  out  2  registered to memory stage.
- cc_out  out  3  {ZF,SF,OF}, for debug.

Behaviour:
- Icode map: 0 halt, 1 nop, 2 rrmov/cmov, 3 irmov, 4 rmmov, 5 mrmov, 6 OPq, 7 jXX, 8 call, 9 ret, 10 push, 11 pop.
- aluA selection:
  - valA for 2 and 6.
  - valC for 3, 4, 5.
  - -8 for 8 and 10.
  - +8 for 9 and 11.
  - 0 otherwise.
- aluB selection: valB for 4, 5, 6, 8, 9, 10, 11; 0 otherwise.
- ALU function: ifun for icode 6, add otherwise. 0 add (B+A), 1 sub (B-A), 2 and, 3 xor. Any other ifun with icode 6 gives 0.
- All arithmetic is W-bit two's complement; carry-out is discarded.
- Flags:
  - ZF = (result == 0).
  - SF = result[W-1].
  - OF: add = (A,B same sign) and (result sign differs from A); sub = (A,B signs differ) and (result sign differs from B); and/xor = 0.
- CC update: at posedge, only when icode==6 and m_stat==0 and W_stat==0 and E_stat==0.
- Conditions from the current CC, by ifun:
  - 0 always true.
  - 1 le = (SF^OF)|ZF.
  - 2 l = SF^OF.
  - 3 e = ZF.
  - 4 ne = ~ZF.
  - 5 ge = ~(SF^OF).
  - 6 g = ~(SF^OF)&~ZF.
  - ifun >= 7 gives 0.
- e_Cnd is meaningful for icodes 2 and 7 only; it is driven to 0 otherwise.
- e_dstE = RNONE when icode==2 and !e_Cnd; else E_dstE.
- An instruction in the same cycle as a CC write sees the old CC (register read before update). No internal CC bypass.
- M register priority at posedge, highest first:
  - rst: M_icode=1, M_stat=0, M_dstE=M_dstM=RNONE, all others 0; CC={1,0,0}.
  - M_stall: hold all M fields.
  - M_bubble: same values as reset for the M fields; CC still updates if its own condition holds.
  - else load: M_icode=E_icode, M_Cnd=e_Cnd, M_valE=e_valE, M_valA=E_valA, M_dstE=e_dstE, M_dstM=E_dstM, M_stat=E_stat.
- Latency: combinational outputs appear in the same cycle; M fields are one cycle later.
- Reset mid-operation discards any in-flight instruction; no partial CC write occurs.
- A bubble and a stall asserted together: the stall wins.

Decomposition:
- Shared package holds:
  - icode constants (IHALT..IPOPQ).
  - ALU function codes.
  - condition function codes.
  - stat codes (SAOK, SHLT, SADR, SINS).
  - RNONE.
  - CC reset value.
- One sub-module, alu_cc: pure combinational ALU plus flag generation, taking (aluA, aluB, alufun) and returning (result, ZF, SF, OF).
- The condition evaluation and the M register stay in execute_stage.

Test Plan:
- OPq sub, valA=5, valB=5 -> e_valE=0; next cycle cc_out=100. A following jXX je (ifun 3) gives e_Cnd=1.
- OPq add, valA=64'h7FFF_FFFF_FFFF_FFFF, valB=1 -> e_valE=64'h8000_0000_0000_0000; CC becomes ZF=0, SF=1, OF=1. Then jl (ifun 2) gives e_Cnd=0.
- cmovne (icode 2, ifun 4) with ZF=1, E_dstE=3 -> e_dstE=15, M_dstE=15. With ZF=0 -> e_dstE=3, M_valE=valA.
- OPq add with m_stat=2 -> CC unchanged, while M_valE is still loaded with the sum.
- pushq, valB=64'h100 -> e_valE=64'hF8. popq, valB=64'h100 -> e_valE=64'h108; M_dstM=E_dstM, M_valA=E_valA.
- M_stall high for 2 cycles while E changes -> M fields frozen. M_bubble -> M_icode=1, M_dstE=15. rst mid-stream -> all M fields at their reset values, cc_out=100.
